bsg_upstream_link_arb: RTL and testbench
========================================

// Module: bsg_upstream_link_arb
// PURPOSE
// - Shares one off-chip upstream link among NUM_REQ core-side requesters; sits in front of the upstream serializer.
// - Round-robin selects one flit per grant and presents it on a registered valid/ready link port.
// - Owns link flow control: a credit counter consumed per flit and replenished by token pulses from the far end.
// PARAMETERS
// - NUM_REQ       4   number of requesters (>=2)
// - DATA_W        8   flit width in bits
// - MAX_CREDITS   8   credits at reset; also the saturation ceiling
// - TOKEN_WEIGHT  4   credits returned per token_i pulse
// - BURST_LEN     4   max consecutive grants to one requester (used only with UPSTREAM_ARB_BURST_EN)
// PORTS
// - clk             in   1                 clock
// - rst             in   1                 reset, synchronous, active-high
// - req_valid_i     in   NUM_REQ           per-requester flit valid
// - req_data_i      in   NUM_REQ*DATA_W    per-requester flit; requester i at [i*DATA_W +: DATA_W]
// - req_ready_o     out  NUM_REQ           one-hot accept strobe (combinational)
// - link_valid_o    out  1                 registered flit valid toward serializer
// - link_data_o     out  DATA_W            registered flit data
// - link_src_o      out  SRC_W             index of the source requester, SRC_W=$clog2(NUM_REQ)
// - link_ready_i    in   1                 serializer accepts the flit
// - token_i         in   1                 one-cycle credit-return pulse, already synchronous to clk
// - credits_o       out  CNT_W             current credits, CNT_W=$clog2(MAX_CREDITS+1)
// - stall_o         out  1                 any req_valid_i high while credits_o==0
// - overflow_err_o  out  1                 sticky: a token return exceeded MAX_CREDITS
// BEHAVIOUR
// - Reset: link_valid_o=0, link_data_o=0, link_src_o=0, credits_o=MAX_CREDITS, overflow_err_o=0, rr pointer=NUM_REQ-1 (requester 0 wins first).
// - FSM: IDLE (output stage empty) / HOLD (link_valid_o=1, awaiting link_ready_i).
// - load = (IDLE || link_ready_i) && credits_o!=0 && |req_valid_i. Credit check uses the registered count only; a same-cycle token does not enable a load.
// - On load: grant = first valid requester after rr pointer (wrapping); req_ready_o[grant]=1, all others 0; flit, src registered; state HOLD next cycle.
// - Latency: accept in cycle N -> link_valid_o in cycle N+1. Back-to-back loads under continuous link_ready_i give one flit per cycle.
// - HOLD && !link_ready_i: link_data_o/link_src_o stable, req_ready_o=0.
// - HOLD && link_ready_i && !load: -> IDLE, link_valid_o=0.
// - Credits: next = credits - load + (token_i ? TOKEN_WEIGHT : 0), computed in CNT_W+1 bits; if > MAX_CREDITS saturate to MAX_CREDITS and set overflow_err_o (cleared only by rst).
// - Never decrements below 0 (load is gated by credits!=0).
// - Reset mid-operation: held flit dropped, credits restored to MAX_CREDITS; requester must resend.
// CONFIGURATION
// - UPSTREAM_ARB_BURST_EN defined: pointer stays on the granted requester while it keeps req_valid_i high, up to BURST_LEN consecutive loads, then advances; burst counter resets on requester switch or drop of valid.
// - Not defined: pointer advances to the granted index after every load (strict per-flit round robin); BURST_LEN ignored.
// STRUCTURE
// - Package bsg_upstream_link_pkg: link_state_e {IDLE,HOLD}, flit_t (DATA_W data + SRC_W src), credit width helper constants.
// - Sub-module bsg_upstream_rr_arb: combinational round-robin pick from req vector + pointer, returns one-hot grant and index.
// - Top holds output register, FSM, credit counter, pointer/burst counter.
// TESTING (NUM_REQ=4, DATA_W=8, MAX_CREDITS=8, TOKEN_WEIGHT=4)
// - Reset: rst 2 cycles -> link_valid_o=0, credits_o=8, req_ready_o=4'b0000, overflow_err_o=0.
// - All 4 valid, link_ready_i=1, no tokens, burst off -> link_src_o 0,1,2,3,0,1,2,3; then credits_o=0, stall_o=1, link_valid_o=0.
// - At credits_o=0, one token_i pulse -> credits_o=4 next cycle; exactly 4 more flits, then stall.
// - Req 2 data 8'hA5, link_ready_i=0 for 5 cycles -> link_data_o=8'hA5, link_src_o=2 held, req_ready_o=0 throughout.
// - credits_o=3, load and token_i same cycle -> credits_o=6; token at credits_o=8 -> stays 8, overflow_err_o=1 until rst.
// - Burst on, BURST_LEN=4, req 0 and 1 always valid -> sources 0,0,0,0,1,1,1,1 (with tokens keeping credits up).

Source files
------------

// File: rtl/bsg_upstream_link_pkg.sv
// Shared types and width helpers for the upstream link arbiter.
//   link_state_e : output-stage state (IDLE = empty, HOLD = flit presented)
//   flit_t       : flit as seen by the serializer (data + source index), default widths
//   credit_cnt_w : width of a credit counter able to hold 0..max_credits
package bsg_upstream_link_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } link_state_e;

  localparam int unsigned FLIT_DATA_W = 8;
  localparam int unsigned FLIT_SRC_W  = 2;

  typedef struct packed {
    logic [FLIT_DATA_W-1:0] data;
    logic [FLIT_SRC_W-1:0]  src;
  } flit_t;

  function automatic int unsigned credit_cnt_w(input int unsigned max_credits);
    return $clog2(max_credits + 1);
  endfunction

endpackage

// File: rtl/bsg_upstream_rr_arb.sv
// Combinational round-robin pick.
//   req_i   : request vector
//   ptr_i   : last-served index; search starts at ptr_i+1 and wraps
//   grant_o : one-hot grant (all zero when no request)
//   idx_o   : binary index of the granted requester
//   valid_o : some requester was granted
module bsg_upstream_rr_arb #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned SRC_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SRC_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [SRC_W-1:0]   idx_o,
  output logic               valid_o
);

  always_comb begin
    int unsigned cand;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = (32'(ptr_i) + off) % NUM_REQ;
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand[SRC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bsg_upstream_link_arb.sv
// Upstream link arbiter: round-robin shares one credit-controlled link among
// NUM_REQ requesters and presents one registered flit at a time.
//   clk, rst        : clock, synchronous active-high reset
//   req_valid_i/    : per-requester flit valid / data (requester i at [i*DATA_W +: DATA_W])
//   req_data_i
//   req_ready_o     : one-hot accept strobe (combinational)
//   link_valid_o/   : registered flit toward the serializer, with source index
//   link_data_o/link_src_o, link_ready_i : serializer handshake
//   token_i         : credit-return pulse, worth TOKEN_WEIGHT credits
//   credits_o       : current credit count
//   stall_o         : requests pending with no credits
//   overflow_err_o  : sticky, a token return exceeded MAX_CREDITS
// Build option: UPSTREAM_ARB_BURST_EN keeps the grant on one requester for up to
// BURST_LEN consecutive flits; otherwise strict per-flit round robin.
module bsg_upstream_link_arb
  import bsg_upstream_link_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned MAX_CREDITS  = 8,
  parameter int unsigned TOKEN_WEIGHT = 4,
  parameter int unsigned BURST_LEN    = 4,
  localparam int unsigned SRC_W       = $clog2(NUM_REQ),
  localparam int unsigned CNT_W       = credit_cnt_w(MAX_CREDITS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      link_valid_o,
  output logic [DATA_W-1:0]         link_data_o,
  output logic [SRC_W-1:0]          link_src_o,
  input  logic                      link_ready_i,
  input  logic                      token_i,
  output logic [CNT_W-1:0]          credits_o,
  output logic                      stall_o,
  output logic                      overflow_err_o
);

  localparam logic [CNT_W:0]   MaxCred  = (CNT_W+1)'(MAX_CREDITS);
  localparam logic [CNT_W:0]   TokenInc = (CNT_W+1)'(TOKEN_WEIGHT);
  localparam logic [SRC_W-1:0] LastIdx  = SRC_W'(NUM_REQ - 1);

  link_state_e         state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic [SRC_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    cred_q, cred_d;
  logic [CNT_W:0]      cred_sum;
  logic                ovf_q, ovf_d;
  logic [NUM_REQ-1:0]  gnt_oh;
  logic [SRC_W-1:0]    gnt_idx;
  logic                gnt_any;
  logic                load;

  bsg_upstream_rr_arb #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arb (
    .req_i  (req_valid_i),
    .ptr_i  (ptr_q),
    .grant_o(gnt_oh),
    .idx_o  (gnt_idx),
    .valid_o(gnt_any)
  );

  // Registered credit count only; a same-cycle token cannot enable a load.
  // Gated by rst so nothing is acknowledged that reset is about to drop.
  assign load = !rst && (state_q == IDLE || link_ready_i) && (cred_q != '0) && gnt_any;

  assign req_ready_o    = load ? gnt_oh : '0;
  assign link_valid_o   = (state_q == HOLD);
  assign link_data_o    = data_q;
  assign link_src_o     = src_q;
  assign credits_o      = cred_q;
  assign stall_o        = (|req_valid_i) && (cred_q == '0);
  assign overflow_err_o = ovf_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    if (load) begin
      state_d = HOLD;
      data_d  = req_data_i[gnt_idx*DATA_W +: DATA_W];
      src_d   = gnt_idx;
    end else if (state_q == HOLD && link_ready_i) begin
      state_d = IDLE;
    end
  end

  // One bit of headroom so a token return above the ceiling is detectable.
  always_comb begin
    cred_sum = {1'b0, cred_q} - (CNT_W+1)'(load) + (token_i ? TokenInc : '0);
    ovf_d    = ovf_q;
    if (cred_sum > MaxCred) begin
      cred_d = MaxCred[CNT_W-1:0];
      ovf_d  = 1'b1;
    end else begin
      cred_d = cred_sum[CNT_W-1:0];
    end
  end

`ifdef UPSTREAM_ARB_BURST_EN
  localparam int unsigned BurstW = $clog2(BURST_LEN + 1);

  logic [BurstW-1:0] burst_q, burst_d, burst_nxt;
  logic [SRC_W-1:0]  last_q, last_d;

  // Parking the pointer one below the granted index makes it win again next time.
  always_comb begin
    ptr_d     = ptr_q;
    burst_d   = burst_q;
    last_d    = last_q;
    burst_nxt = (gnt_idx == last_q && burst_q != '0) ? burst_q + BurstW'(1) : BurstW'(1);
    if (load) begin
      last_d = gnt_idx;
      if (burst_nxt == BurstW'(BURST_LEN)) begin
        ptr_d   = gnt_idx;
        burst_d = '0;
      end else begin
        ptr_d   = (gnt_idx == '0) ? LastIdx : gnt_idx - SRC_W'(1);
        burst_d = burst_nxt;
      end
    end else if (burst_q != '0 && !req_valid_i[last_q]) begin
      ptr_d   = last_q;
      burst_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_q <= '0;
      last_q  <= '0;
    end else begin
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end
`else
  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = gnt_idx;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= LastIdx;
      cred_q  <= MaxCred[CNT_W-1:0];
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      cred_q  <= cred_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_bsg_upstream_link_arb.sv
module tb_bsg_upstream_link_arb;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXC = 8;
  localparam int TW   = 4;
  localparam int BL   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid_i;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]  req_ready_o;
  logic          link_valid_o;
  logic [DW-1:0] link_data_o;
  logic [1:0]    link_src_o;
  logic          link_ready_i;
  logic          token_i;
  logic [3:0]    credits_o;
  logic          stall_o;
  logic          overflow_err_o;

  bsg_upstream_link_arb #(
    .NUM_REQ(N), .DATA_W(DW), .MAX_CREDITS(MAXC), .TOKEN_WEIGHT(TW), .BURST_LEN(BL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_data_i    (req_data_i),
    .req_ready_o   (req_ready_o),
    .link_valid_o  (link_valid_o),
    .link_data_o   (link_data_o),
    .link_src_o    (link_src_o),
    .link_ready_i  (link_ready_i),
    .token_i       (token_i),
    .credits_o     (credits_o),
    .stall_o       (stall_o),
    .overflow_err_o(overflow_err_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: abstract link state plus a queue of expected flits {src, data}.
  int          m_cred, m_ptr, m_last, m_run;
  bit          m_hold, m_ovf;
  logic [15:0] sb[$];

  task automatic model_reset();
    m_cred = MAXC;
    m_ptr  = N - 1;
    m_hold = 1'b0;
    m_ovf  = 1'b0;
    m_last = 0;
    m_run  = 0;
    sb.delete();
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                      input logic rdy, input logic tok, input logic r);
    int g;
    bit can;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    rst = r; req_valid_i = v; req_data_i = d; link_ready_i = rdy; token_i = tok;
    #1;
    if (r) begin
      chk("req_ready_in_reset", req_ready_o, 0);
      model_reset();
      return;
    end
    chk("credits", credits_o, m_cred);
    chk("link_valid", link_valid_o, m_hold);
    chk("overflow_err", overflow_err_o, m_ovf);
    chk("stall", stall_o, (v != 0 && m_cred == 0));
    can = (!m_hold || rdy) && m_cred != 0 && v != 0;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (g < 0 && v[c]) g = c;
    end
    exp_rdy = '0;
    if (can) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready_o, exp_rdy);
    if (can) begin
      sb.push_back({g[7:0], d[g*DW +: DW]});
      m_hold = 1'b1;
    end else if (rdy) begin
      m_hold = 1'b0;
    end
    m_cred = m_cred - int'(can) + (tok ? TW : 0);
    if (m_cred > MAXC) begin
      m_cred = MAXC;
      m_ovf  = 1'b1;
    end
`ifdef UPSTREAM_ARB_BURST_EN
    if (can) begin
      m_run  = (g == m_last && m_run > 0) ? m_run + 1 : 1;
      m_last = g;
      if (m_run == BL) begin
        m_ptr = g;
        m_run = 0;
      end else begin
        m_ptr = (g + N - 1) % N;
      end
    end else if (m_run > 0 && !v[m_last]) begin
      m_run = 0;
      m_ptr = m_last;
    end
`else
    if (can) m_ptr = g;
`endif
  endtask

  // Monitor: whenever a flit is presented, it must match the oldest expected flit;
  // it retires on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst !== 1'b1 && link_valid_o === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL flit_unexpected: got src %0d data %0h with empty scoreboard",
                   link_src_o, link_data_o);
        end else begin
          chk("link_data", link_data_o, sb[0][7:0]);
          chk("link_src", link_src_o, sb[0][15:8]);
          if (link_ready_i) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid_i = '0; req_data_i = '0; link_ready_i = 1'b0; token_i = 1'b0;
    model_reset();

    // Reset state
    step(4'h0, '0, 1'b0, 1'b0, 1'b1);
    step(4'h0, '0, 1'b0, 1'b0, 1'b1);
    step(4'h0, '0, 1'b1, 1'b0, 1'b0);
    chk("reset_credits", credits_o, 8);
    chk("reset_valid", link_valid_o, 0);
    chk("reset_ready", req_ready_o, 0);
    chk("reset_ovf", overflow_err_o, 0);

    // All requesters, continuous ready, no tokens: 8 flits then stall
    repeat (10) step(4'hF, $urandom, 1'b1, 1'b0, 1'b0);
    chk("drain_credits", credits_o, 0);
    chk("drain_stall", stall_o, 1);
    chk("drain_valid", link_valid_o, 0);

    // One token at zero credits: no same-cycle load, then exactly 4 flits
    step(4'hF, $urandom, 1'b1, 1'b1, 1'b0);
    chk("token_no_load", req_ready_o, 0);
    step(4'hF, $urandom, 1'b1, 1'b0, 1'b0);
    chk("token_credits", credits_o, 4);
    repeat (6) step(4'hF, $urandom, 1'b1, 1'b0, 1'b0);
    chk("token_stall", stall_o, 1);

    // Held flit under backpressure
    step(4'h0, '0, 1'b0, 1'b0, 1'b1);
    step(4'b0100, 32'h00A5_0000, 1'b0, 1'b0, 1'b0);
    repeat (5) step(4'b0100, $urandom, 1'b0, 1'b0, 1'b0);
    chk("hold_data", link_data_o, 8'hA5);
    chk("hold_src", link_src_o, 2);
    step(4'h0, '0, 1'b1, 1'b0, 1'b0);
    step(4'h0, '0, 1'b1, 1'b0, 1'b0);

    // Load + token together at 3 credits, then saturation
    step(4'h0, '0, 1'b0, 1'b0, 1'b1);
    repeat (5) step(4'hF, $urandom, 1'b1, 1'b0, 1'b0);
    step(4'hF, $urandom, 1'b1, 1'b1, 1'b0);
    step(4'h0, '0, 1'b1, 1'b0, 1'b0);
    chk("load_token_credits", credits_o, 6);
    step(4'h0, '0, 1'b1, 1'b1, 1'b0);
    step(4'h0, '0, 1'b1, 1'b1, 1'b0);
    step(4'h0, '0, 1'b1, 1'b0, 1'b0);
    chk("sat_credits", credits_o, 8);
    chk("sat_ovf", overflow_err_o, 1);
    repeat (3) step(4'h0, '0, 1'b1, 1'b0, 1'b0);
    chk("ovf_sticky", overflow_err_o, 1);

`ifdef UPSTREAM_ARB_BURST_EN
    step(4'h0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(4'b0011, $urandom, 1'b1, 1'(i % 2), 1'b0);
`endif

    // Randomized traffic with occasional reset
    repeat (3000) begin
      step(4'($urandom), $urandom, 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 9) < 2), 1'($urandom_range(0, 199) == 0));
    end
    step(4'h0, '0, 1'b1, 1'b0, 1'b0);
    step(4'h0, '0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
